// File: rtl/macc_dot_sequencer.sv
// macc_dot_sequencer: drives one signed MACC unit (2-stage input/mult pipeline plus
// loadable accumulator) to form the dot product of two vectors held in sync-read
// memories A and B. A job is accepted in IDLE, operands are streamed during FETCH,
// DRAIN lets the MACC pipeline empty, and DONE presents the sum on a valid/ready port.
module macc_dot_sequencer #(
    parameter int SIZEIN  = 16,
    parameter int SIZEOUT = 40,
    parameter int ADDR_W  = 10
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [ADDR_W-1:0]         cfg_base_a,
    input  logic [ADDR_W-1:0]         cfg_base_b,
    input  logic [ADDR_W:0]           cfg_len,
    output logic                      busy,
    output logic                      mem_a_en,
    output logic [ADDR_W-1:0]         mem_a_addr,
    input  logic signed [SIZEIN-1:0]  mem_a_dout,
    output logic                      mem_b_en,
    output logic [ADDR_W-1:0]         mem_b_addr,
    input  logic signed [SIZEIN-1:0]  mem_b_dout,
    output logic                      mac_ce,
    output logic                      mac_sload,
    output logic signed [SIZEIN-1:0]  mac_a,
    output logic signed [SIZEIN-1:0]  mac_b,
    input  logic signed [SIZEOUT-1:0] mac_accum,
    output logic                      res_valid,
    output logic signed [SIZEOUT-1:0] res_data,
    input  logic                      res_ready
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        DONE
    } state_t;

    localparam logic [ADDR_W:0]   LEN_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   k;
    logic [1:0]        drain_cnt;
    logic              issue;
    logic              sload_pre;

    // Memory data arrives one cycle after each enabled read, so operands pass straight
    // through while issue is high and are forced to zero otherwise.
    assign mac_a = issue ? mem_a_dout : '0;
    assign mac_b = issue ? mem_b_dout : '0;

    // Job sequencing FSM; every control output is registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            len_q      <= '0;
            k          <= '0;
            drain_cnt  <= '0;
            issue      <= 1'b0;
            sload_pre  <= 1'b0;
            busy       <= 1'b0;
            mem_a_en   <= 1'b0;
            mem_b_en   <= 1'b0;
            mem_a_addr <= '0;
            mem_b_addr <= '0;
            mac_ce     <= 1'b0;
            mac_sload  <= 1'b0;
            res_valid  <= 1'b0;
            res_data   <= '0;
        end else begin
            // Issue window trails the read-enable window by the memory read latency;
            // the accumulator restart lands two cycles after the first fetch cycle so it
            // meets the first product at the MACC adder.
            issue     <= mem_a_en;
            sload_pre <= (state == FETCH) && (k == '0);
            mac_sload <= sload_pre;

            case (state)
                IDLE: begin
                    if (start) begin
                        busy       <= 1'b1;
                        len_q      <= cfg_len;
                        k          <= '0;
                        mem_a_addr <= cfg_base_a;
                        mem_b_addr <= cfg_base_b;
                        if (cfg_len == '0) begin
                            state <= DONE;
                        end else begin
                            mem_a_en <= 1'b1;
                            mem_b_en <= 1'b1;
                            state    <= FETCH;
                        end
                    end
                end

                FETCH: begin
                    if (k == '0) begin
                        mac_ce <= 1'b1;
                    end
                    if (k == len_q - LEN_ONE) begin
                        mem_a_en  <= 1'b0;
                        mem_b_en  <= 1'b0;
                        drain_cnt <= '0;
                        state     <= DRAIN;
                    end else begin
                        k          <= k + LEN_ONE;
                        mem_a_addr <= mem_a_addr + ADDR_ONE;
                        mem_b_addr <= mem_b_addr + ADDR_ONE;
                    end
                end

                DRAIN: begin
                    if (drain_cnt == 2'd2) begin
                        mac_ce <= 1'b0;
                        state  <= DONE;
                    end else begin
                        drain_cnt <= drain_cnt + 2'd1;
                    end
                end

                DONE: begin
                    if (!res_valid) begin
                        res_data  <= (len_q == '0) ? '0 : mac_accum;
                        res_valid <= 1'b1;
                    end else if (res_ready) begin
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_macc_dot_sequencer.sv
// tb_macc_dot_sequencer: surrounds the sequencer with two sync-read memories and a
// behavioural signed MACC, runs dot-product jobs, and scores results through a queue.
module tb_macc_dot_sequencer;

    localparam int SIZEIN  = 16;
    localparam int SIZEOUT = 40;
    localparam int ADDR_W  = 10;
    localparam int DEPTH   = 1 << ADDR_W;

    logic                      clk;
    logic                      rst_n;
    logic                      start;
    logic [ADDR_W-1:0]         cfg_base_a;
    logic [ADDR_W-1:0]         cfg_base_b;
    logic [ADDR_W:0]           cfg_len;
    logic                      busy;
    logic                      mem_a_en;
    logic [ADDR_W-1:0]         mem_a_addr;
    logic signed [SIZEIN-1:0]  mem_a_dout;
    logic                      mem_b_en;
    logic [ADDR_W-1:0]         mem_b_addr;
    logic signed [SIZEIN-1:0]  mem_b_dout;
    logic                      mac_ce;
    logic                      mac_sload;
    logic signed [SIZEIN-1:0]  mac_a;
    logic signed [SIZEIN-1:0]  mac_b;
    logic signed [SIZEOUT-1:0] mac_accum;
    logic                      res_valid;
    logic signed [SIZEOUT-1:0] res_data;
    logic                      res_ready;

    logic signed [SIZEIN-1:0]  mem_a [DEPTH];
    logic signed [SIZEIN-1:0]  mem_b [DEPTH];

    logic signed [SIZEIN-1:0]  ma_r;
    logic signed [SIZEIN-1:0]  mb_r;
    logic signed [31:0]        mult_r;
    logic                      sload_r;

    logic signed [SIZEOUT-1:0] exp_q [$];
    int                        vectors;
    int                        miscompares;

    macc_dot_sequencer #(
        .SIZEIN (SIZEIN),
        .SIZEOUT(SIZEOUT),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .cfg_base_a(cfg_base_a),
        .cfg_base_b(cfg_base_b),
        .cfg_len   (cfg_len),
        .busy      (busy),
        .mem_a_en  (mem_a_en),
        .mem_a_addr(mem_a_addr),
        .mem_a_dout(mem_a_dout),
        .mem_b_en  (mem_b_en),
        .mem_b_addr(mem_b_addr),
        .mem_b_dout(mem_b_dout),
        .mac_ce    (mac_ce),
        .mac_sload (mac_sload),
        .mac_a     (mac_a),
        .mac_b     (mac_b),
        .mac_accum (mac_accum),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_ready (res_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sync-read memories: data for an enabled address appears one cycle later.
    always @(posedge clk) begin
        if (mem_a_en) mem_a_dout <= mem_a[mem_a_addr];
        if (mem_b_en) mem_b_dout <= mem_b[mem_b_addr];
    end

    // Behavioural MACC: input regs, product reg, registered sload, accumulator.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma_r      <= '0;
            mb_r      <= '0;
            mult_r    <= '0;
            sload_r   <= 1'b0;
            mac_accum <= '0;
        end else if (mac_ce) begin
            ma_r      <= mac_a;
            mb_r      <= mac_b;
            mult_r    <= ma_r * mb_r;
            sload_r   <= mac_sload;
            mac_accum <= (sload_r ? 40'sd0 : mac_accum) + mult_r;
        end
    end

    // Runs one job from the current cycle (one step after a rising edge) until one
    // cycle after its result handshake, checking control timing, operands, latency,
    // hold behaviour and the scoreboarded result.
    task automatic run_job(input int ba, input int bb, input int len, input int hold,
                           input bit stray);
        logic signed [SIZEOUT-1:0] sum;
        logic signed [SIZEOUT-1:0] exp_res;
        logic signed [SIZEOUT-1:0] held;
        logic signed [31:0]        p;
        logic [4:0]                exp_ctl;
        logic [31:0]               exp_ops;
        logic [ADDR_W-1:0]         ea;
        logic [ADDR_W-1:0]         eb;
        int                        exp_lat;
        int                        limit;
        int                        vt;
        bit                        seen;
        bit                        done;

        sum = '0;
        for (int k = 0; k < len; k++) begin
            p   = mem_a[(ba + k) % DEPTH] * mem_b[(bb + k) % DEPTH];
            sum = sum + p;
        end
        exp_q.push_back(sum);

        exp_lat = (len == 0) ? 2 : len + 5;
        limit   = exp_lat + hold + 10;
        held    = '0;
        seen    = 1'b0;
        done    = 1'b0;
        vt      = 0;

        cfg_base_a = ADDR_W'(ba);
        cfg_base_b = ADDR_W'(bb);
        cfg_len    = (ADDR_W + 1)'(len);
        start      = 1'b1;

        for (int t = 1; t <= limit && !done; t++) begin
            @(posedge clk);
            #1;
            start = stray && (t == 2);
            if (stray && t == 2) begin
                cfg_len    = 11'd7;
                cfg_base_a = 10'd500;
            end

            if (seen && t == vt + hold + 1) begin
                res_ready = 1'b0;
                vectors++;
                if ({res_valid, busy} !== 2'b00) begin
                    miscompares++;
                    $display("[TB] FAIL post_handshake t=%0d: {res_valid,busy}=%b required 00",
                             t, {res_valid, busy});
                end
                done = 1'b1;
            end else if (!seen && !res_valid) begin
                exp_ctl[4] = 1'b1;
                exp_ctl[3] = (t >= 1) && (t <= len);
                exp_ctl[2] = (t >= 1) && (t <= len);
                exp_ctl[1] = (len > 0) && (t >= 2) && (t <= len + 3);
                exp_ctl[0] = (len > 0) && (t == 3);
                vectors++;
                if ({busy, mem_a_en, mem_b_en, mac_ce, mac_sload} !== exp_ctl) begin
                    miscompares++;
                    $display("[TB] FAIL control t=%0d: {busy,a_en,b_en,ce,sload}=%b required %b",
                             t, {busy, mem_a_en, mem_b_en, mac_ce, mac_sload}, exp_ctl);
                end
                if (exp_ctl[3]) begin
                    ea = ADDR_W'((ba + t - 1) % DEPTH);
                    eb = ADDR_W'((bb + t - 1) % DEPTH);
                    vectors++;
                    if ({mem_a_addr, mem_b_addr} !== {ea, eb}) begin
                        miscompares++;
                        $display("[TB] FAIL addr t=%0d: a=%0d b=%0d required a=%0d b=%0d",
                                 t, mem_a_addr, mem_b_addr, ea, eb);
                    end
                end
                if (t >= 2 && t <= len + 1)
                    exp_ops = {mem_a[(ba + t - 2) % DEPTH], mem_b[(bb + t - 2) % DEPTH]};
                else
                    exp_ops = '0;
                vectors++;
                if ({mac_a, mac_b} !== exp_ops) begin
                    miscompares++;
                    $display("[TB] FAIL operands t=%0d: {mac_a,mac_b}=%h required %h",
                             t, {mac_a, mac_b}, exp_ops);
                end
            end else begin
                if (!seen) begin
                    seen = 1'b1;
                    vt   = t;
                    held = res_data;
                    vectors++;
                    if (t !== exp_lat) begin
                        miscompares++;
                        $display("[TB] FAIL latency: res_valid at S+%0d required S+%0d", t, exp_lat);
                    end
                end else begin
                    vectors++;
                    if ({res_valid, res_data} !== {1'b1, held}) begin
                        miscompares++;
                        $display("[TB] FAIL hold t=%0d: valid=%b data=%0d required valid=1 data=%0d",
                                 t, res_valid, res_data, held);
                    end
                end
                if (t - vt == hold) begin
                    res_ready = 1'b1;
                    vectors++;
                    if (exp_q.size() == 0) begin
                        miscompares++;
                        $display("[TB] FAIL scoreboard: result %0d with nothing expected", res_data);
                    end else begin
                        exp_res = exp_q.pop_front();
                        if (res_data !== exp_res) begin
                            miscompares++;
                            $display("[TB] FAIL result: res_data=%0d required %0d", res_data, exp_res);
                        end
                    end
                end
            end
        end

        if (!done) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL timeout: job len=%0d did not complete within %0d cycles", len, limit);
            res_ready = 1'b0;
            start     = 1'b0;
        end

        if (stray) begin
            for (int i = 0; i < 3; i++) begin
                @(posedge clk);
                #1;
                vectors++;
                if ({busy, mem_a_en, mac_ce} !== 3'b000) begin
                    miscompares++;
                    $display("[TB] FAIL stray_start: {busy,a_en,ce}=%b required 000",
                             {busy, mem_a_en, mac_ce});
                end
            end
        end
    endtask

    // Reset holds every output at zero even with start asserted.
    task automatic test_reset();
        rst_n      = 1'b0;
        start      = 1'b1;
        res_ready  = 1'b0;
        cfg_base_a = '0;
        cfg_base_b = '0;
        cfg_len    = 11'd4;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({busy, mem_a_en, mem_b_en, mac_ce, mac_sload, res_valid} !== 6'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_ctl: %b required 000000",
                     {busy, mem_a_en, mem_b_en, mac_ce, mac_sload, res_valid});
        end
        vectors++;
        if ({mem_a_addr, mem_b_addr, mac_a, mac_b, res_data} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_data: addr_a=%0d addr_b=%0d mac_a=%0d mac_b=%0d res=%0d required 0",
                     mem_a_addr, mem_b_addr, mac_a, mac_b, res_data);
        end
        start = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Basic four-element product with the stated latency.
    task automatic test_basic();
        for (int i = 0; i < 4; i++) begin
            mem_a[i]       = 16'(i + 1);
            mem_b[100 + i] = 16'(i + 5);
        end
        run_job(0, 100, 4, 0, 1'b0);
    endtask

    // Extreme operands: products of -32768 squared must accumulate without saturation.
    task automatic test_overflow();
        mem_a[40] = -16'sd32768;
        mem_a[41] = -16'sd32768;
        mem_a[42] = 16'sd1;
        mem_b[140] = -16'sd32768;
        mem_b[141] = -16'sd32768;
        mem_b[142] = -16'sd1;
        run_job(40, 140, 3, 0, 1'b1);
    endtask

    // Second job starts in the first IDLE cycle; sload must discard the old sum.
    task automatic test_back_to_back();
        mem_a[10] = 16'sd3;
        mem_a[11] = 16'sd4;
        mem_b[110] = 16'sd5;
        mem_b[111] = 16'sd6;
        mem_a[20] = 16'sd1;
        mem_a[21] = 16'sd1;
        mem_b[120] = 16'sd1;
        mem_b[121] = 16'sd1;
        run_job(10, 110, 2, 0, 1'b0);
        run_job(20, 120, 2, 0, 1'b0);
    endtask

    // Zero-length job: immediate zero result, MACC left idle, stray start ignored.
    task automatic test_zero_len();
        run_job(0, 0, 0, 0, 1'b1);
    endtask

    // Consumer stalls five cycles while addresses wrap from the top of memory.
    task automatic test_backpressure_wrap();
        mem_a[1022] = 16'sd2;
        mem_a[1023] = -16'sd3;
        mem_a[0]    = 16'sd4;
        mem_a[1]    = 16'sd5;
        mem_b[1022] = 16'sd7;
        mem_b[1023] = 16'sd8;
        mem_b[0]    = -16'sd9;
        mem_b[1]    = 16'sd10;
        run_job(1022, 1022, 4, 5, 1'b0);
    endtask

    // Reset in the middle of FETCH clears outputs at once; a fresh job then works.
    task automatic test_reset_mid_job();
        for (int i = 0; i < 5; i++) begin
            mem_a[200 + i] = 16'(i * 7 - 9);
            mem_b[300 + i] = 16'(11 - i * 3);
        end
        cfg_base_a = 10'd200;
        cfg_base_b = 10'd300;
        cfg_len    = 11'd5;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({busy, mem_a_en, mem_b_en, mac_ce, mac_sload, res_valid} !== 6'b0) begin
            miscompares++;
            $display("[TB] FAIL midreset_ctl: %b required 000000",
                     {busy, mem_a_en, mem_b_en, mac_ce, mac_sload, res_valid});
        end
        vectors++;
        if ({mem_a_addr, mem_b_addr, mac_a, mac_b, res_data} !== '0) begin
            miscompares++;
            $display("[TB] FAIL midreset_data: addr_a=%0d addr_b=%0d mac_a=%0d mac_b=%0d res=%0d required 0",
                     mem_a_addr, mem_b_addr, mac_a, mac_b, res_data);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if ({busy, res_valid} !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL midreset_abort: {busy,res_valid}=%b required 00", {busy, res_valid});
        end
        run_job(200, 300, 5, 1, 1'b0);
    endtask

    // Global bound so a stuck design still produces a verdict.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Test sequence.
    initial begin
        vectors     = 0;
        miscompares = 0;
        for (int i = 0; i < DEPTH; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end
        mem_a_dout = '0;
        mem_b_dout = '0;

        test_reset();
        test_basic();
        test_overflow();
        test_back_to_back();
        test_zero_len();
        test_backpressure_wrap();
        test_reset_mid_job();

        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL scoreboard_drain: %0d results outstanding required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
